mul_seq_6801: RTL

MUL_SEQ_6801 -- requirements
Module: mul_seq_6801

---
 rtl/mul_seq_6801.sv | 95 +++++++++
 1 files changed

// File: rtl/mul_seq_6801.sv
// Unsigned shift-add multiplier: WIDTH CALC cycles after the start edge, then a one-cycle done pulse.
// hold freezes every register; a held DONE keeps done high until one non-held cycle completes it.
module mul_seq_6801 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 hold,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 c_out
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q,  mplr_d;
  logic [WIDTH-1:0]     acc_q,   acc_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH:0]       sum;

  // The extra sum bit is the carry that shifts into the accumulator MSB.
  assign sum = {1'b0, acc_q} + ({1'b0, mcand_q} & {(WIDTH+1){mplr_q[0]}});

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (!hold) begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            mcand_d = a_in;
            mplr_d  = b_in;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
        CALC: begin
          acc_d  = sum[WIDTH:1];
          mplr_d = {sum[0], mplr_q[WIDTH-1:1]};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            state_d   = DONE;
            product_d = {sum[WIDTH:1], sum[0], mplr_q[WIDTH-1:1]};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = product_q;
  assign c_out   = product_q[WIDTH-1];

endmodule
